// File: rtl/exec_muldiv.sv
// exec_muldiv: iterative RV32M/RV64M multiply/divide unit with stall and valid/ready result handshake
module exec_muldiv #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rd1,
   input  logic [XLEN-1:0] rd2,
   input  logic [XLEN-1:0] result_w,
   input  logic [XLEN-1:0] alu_result_m,
   input  logic [1:0]      forward_a_e,
   input  logic [1:0]      forward_b_e,
   input  logic [4:0]      rd_in,
   output logic            in_ready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            stall_e
);
   localparam int CW = $clog2(XLEN + 1);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [2:0] op;
   logic neg_q, neg_r, sgn_a, sgn_b, sa, sb, accept, div0, ovf;
   logic [XLEN-1:0] a, b, ma, mb, m, lo, lo_n, spec, fin;
   logic [XLEN:0] hi, hi_n;
   logic [2*XLEN-1:0] prod, prod_c;
   // operand forwarding, sign classification and special-case detection at acceptance
   always_comb begin
      a = forward_a_e == 2'b00 ? rd1 : forward_a_e == 2'b01 ? result_w : forward_a_e == 2'b10 ? alu_result_m : 'x;
      b = forward_b_e == 2'b00 ? rd2 : forward_b_e == 2'b01 ? result_w : forward_b_e == 2'b10 ? alu_result_m : 'x;
      sgn_a = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
      sgn_b = funct3 inside {3'b001, 3'b100, 3'b110};
      sa = sgn_a & a[XLEN-1];
      sb = sgn_b & b[XLEN-1];
      ma = sa ? -a : a;
      mb = sb ? -b : b;
      div0 = funct3[2] && b == '0;
      ovf = funct3[2] && !funct3[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
      spec = div0 ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);
      accept = state == IDLE && in_valid && !flush;
   end
   // one CALC step: shift-add for multiply, restoring subtract for divide; plus final sign correction
   always_comb begin
      hi_n = hi;
      lo_n = lo;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (op[2]) begin
            hi_n = {hi_n[XLEN-1:0], lo_n[XLEN-1]};
            lo_n = {lo_n[XLEN-2:0], 1'b0};
            lo_n[0] = hi_n >= {1'b0, m};
            hi_n = lo_n[0] ? hi_n - {1'b0, m} : hi_n;
         end else begin
            hi_n = hi_n + {1'b0, (lo_n[0] ? m : {XLEN{1'b0}})};
            lo_n = {hi_n[0], lo_n[XLEN-1:1]};
            hi_n = hi_n >> 1;
         end
      end
      prod = {hi_n[XLEN-1:0], lo_n};
      prod_c = neg_q ? -prod : prod;
      fin = op[2] ? (op[1] ? (neg_r ? -hi_n[XLEN-1:0] : hi_n[XLEN-1:0]) : (neg_q ? -lo_n : lo_n))
                  : (op[1:0] == 2'b00 ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN]);
   end
   // next-state logic and handshake/stall outputs
   always_comb begin
      state_n = flush ? IDLE
              : state == IDLE ? (in_valid ? (div0 || ovf ? DONE : CALC) : IDLE)
              : state == CALC ? (cnt == CW'(1) ? DONE : CALC)
              : (out_ready ? IDLE : DONE);
      in_ready = state == IDLE;
      out_valid = state == DONE;
      stall_e = accept || state == CALC || (state == DONE && !out_ready);
   end
   // state register
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;
   // operand capture, iteration and result latch
   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
         rd_out <= '0;
      end else if (accept) begin
         op <= funct3;
         rd_out <= rd_in;
         neg_q <= sa ^ sb;
         neg_r <= sa;
         m <= funct3[2] ? mb : ma;
         lo <= funct3[2] ? ma : mb;
         hi <= '0;
         cnt <= CW'(XLEN / BITS_PER_CYCLE);
         if (div0 || ovf) result <= spec;
      end else if (state == CALC && !flush) begin
         hi <= hi_n;
         lo <= lo_n;
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1)) result <= fin;
      end
   end
endmodule

// File: tb/tb_exec_muldiv.sv
// tb_exec_muldiv: randomized self-checking bench against an arithmetic reference model
module tb_exec_muldiv;
   logic clk = 0, rst, flush, in_valid, iv4, out_ready;
   logic [2:0] funct3;
   logic [31:0] rd1, rd2, result_w, alu_result_m;
   logic [1:0] forward_a_e, forward_b_e;
   logic [4:0] rd_in;
   logic in_ready, out_valid, stall_e, in_ready4, out_valid4, stall_e4;
   logic [31:0] result, result4;
   logic [4:0] rd_out, rd_out4;
   int checks = 0, failures = 0;

   exec_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .funct3(funct3),
      .rd1(rd1), .rd2(rd2), .result_w(result_w), .alu_result_m(alu_result_m),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .rd_in(rd_in),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .rd_out(rd_out), .stall_e(stall_e));

   exec_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(iv4), .funct3(funct3),
      .rd1(rd1), .rd2(rd2), .result_w(result_w), .alu_result_m(alu_result_m),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .rd_in(rd_in),
      .in_ready(in_ready4), .out_valid(out_valid4), .out_ready(1'b1),
      .result(result4), .rd_out(rd_out4), .stall_e(stall_e4));

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb;
      logic [63:0] ua, ub, p;
      logic ov;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      ov = a == 32'h80000000 && b == 32'hFFFFFFFF;
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * $signed(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: return b == 0 ? 32'hFFFFFFFF : ov ? a : 32'($signed(a) / $signed(b));
         3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
         3'd6: return b == 0 ? a : ov ? 32'd0 : 32'($signed(a) % $signed(b));
         default: return b == 0 ? a : a % b;
      endcase
   endfunction

   function automatic bit special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
   endfunction

   task automatic wait_valid(inout int lat);
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         output logic [31:0] res, output logic [4:0] rdo, output int lat, output int stalls,
                         output logic stall_hs);
      @(negedge clk);
      funct3 = f; rd1 = a; rd2 = b; forward_a_e = 0; forward_b_e = 0; rd_in = rd; in_valid = 1; out_ready = 1;
      #1 stalls = int'(stall_e);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 0; rd1 = $urandom; rd2 = $urandom;
      while (!out_valid && lat < 100) begin
         stalls += int'(stall_e);
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      res = result; rdo = rd_out; stall_hs = stall_e;
   endtask

   task automatic test_reset();
      rst = 1; flush = 0; in_valid = 0; iv4 = 0; out_ready = 0; funct3 = 0; rd1 = 0; rd2 = 0;
      result_w = 0; alu_result_m = 0; forward_a_e = 0; forward_b_e = 0; rd_in = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
      checks++; if (rd_out !== 5'd0) begin failures++; $display("FAIL reset_rd_out got=%0d exp=0", rd_out); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (stall_e !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_e); end
      rst = 0;
   endtask

   task automatic test_mul();
      logic [31:0] r; logic [4:0] rdo; int lat, st; logic sh;
      run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd11, r, rdo, lat, st, sh);
      checks++; if (r !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffffffeb", r); end
      checks++; if (lat != 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", lat); end
      checks++; if (st != 33) begin failures++; $display("FAIL mul_stall_cycles got=%0d exp=33", st); end
      checks++; if (sh !== 1'b0) begin failures++; $display("FAIL mul_stall_handshake got=%b exp=0", sh); end
      checks++; if (rdo !== 5'd11) begin failures++; $display("FAIL mul_rd_out got=%0d exp=11", rdo); end
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL mul_after_hs in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
   endtask

   task automatic test_table(input string name, input logic [2:0] f[4], input logic [31:0] a[4],
                             input logic [31:0] b[4], input logic [31:0] e[4], input int n, input int elat);
      logic [31:0] r; logic [4:0] rdo; int lat, st; logic sh;
      for (int i = 0; i < n; i++) begin
         run_op(f[i], a[i], b[i], 5'(i + 1), r, rdo, lat, st, sh);
         checks++; if (r !== e[i]) begin failures++; $display("FAIL %s_%0d_result got=%h exp=%h", name, i, r, e[i]); end
         checks++; if (lat != elat) begin failures++; $display("FAIL %s_%0d_latency got=%0d exp=%0d", name, i, lat, elat); end
      end
   endtask

   task automatic test_directed();
      test_table("mulh", '{3'd1, 3'd2, 3'd3, 3'd0}, '{32'h80000000, 32'h80000000, 32'h80000000, 0},
                 '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0}, '{32'h0, 32'h80000000, 32'h7FFFFFFF, 0}, 3, 33);
      test_table("div", '{3'd4, 3'd6, 3'd5, 3'd0}, '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 0},
                 '{32'd2, 32'd2, 32'h10, 0}, '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h08000000, 0}, 3, 33);
      test_table("special", '{3'd4, 3'd6, 3'd4, 3'd6}, '{32'd5, 32'd5, 32'h80000000, 32'h80000000},
                 '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF}, '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0}, 4, 1);
   endtask

   task automatic test_random();
      logic [31:0] r, a, b, e; logic [4:0] rdo, rd; logic [2:0] f; int lat, st, el; logic sh;
      for (int i = 0; i < 30; i++) begin
         f = 3'($urandom_range(0, 7)); a = $urandom; rd = 5'($urandom);
         case ($urandom_range(0, 9))
            0: b = 0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: b = 32'($urandom_range(1, 20));
            3: b = -32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         e = model(f, a, b);
         el = special(f, a, b) ? 1 : 33;
         run_op(f, a, b, rd, r, rdo, lat, st, sh);
         checks++; if (r !== e || rdo !== rd || lat != el)
            begin failures++; $display("FAIL rand_%0d f=%0d a=%h b=%h got=%h/rd%0d/lat%0d exp=%h/rd%0d/lat%0d", i, f, a, b, r, rdo, lat, e, rd, el); end
      end
   endtask

   task automatic test_forward();
      int lat;
      @(negedge clk);
      funct3 = 0; rd1 = 100; rd2 = 100; forward_a_e = 2'b10; alu_result_m = 6; forward_b_e = 2'b01; result_w = 9;
      rd_in = 5'd3; in_valid = 1; out_ready = 1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 0; alu_result_m = 77; result_w = 77; forward_a_e = 0; forward_b_e = 0;
      repeat (5) begin @(posedge clk); lat++; @(negedge clk); end
      rd1 = 32'd1234;
      wait_valid(lat);
      checks++; if (result !== 32'd54 || lat != 33) begin failures++; $display("FAIL forward_mul got=%0d lat=%0d exp=54 lat=33", result, lat); end
   endtask

   task automatic test_flush();
      bit seen = 0;
      @(negedge clk);
      funct3 = 0; rd1 = 3; rd2 = 5; forward_a_e = 0; forward_b_e = 0; in_valid = 1; out_ready = 1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      repeat (9) begin @(posedge clk); @(negedge clk); end
      flush = 1;
      @(posedge clk);
      @(negedge clk);
      flush = 0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || stall_e !== 1'b0)
         begin failures++; $display("FAIL flush_calc in_ready=%b out_valid=%b stall=%b exp=1/0/0", in_ready, out_valid, stall_e); end
      repeat (40) begin @(posedge clk); @(negedge clk); seen |= out_valid; end
      checks++; if (seen) begin failures++; $display("FAIL flush_no_result got out_valid=1 exp=0"); end
      in_valid = 1; flush = 1;
      #1;
      checks++; if (stall_e !== 1'b0) begin failures++; $display("FAIL flush_idle_stall got=%b exp=0", stall_e); end
      @(posedge clk);
      @(negedge clk);
      in_valid = 0; flush = 0;
      checks++; if (in_ready !== 1'b1 || stall_e !== 1'b0) begin failures++; $display("FAIL flush_idle_accept in_ready=%b stall=%b exp=1/0", in_ready, stall_e); end
   endtask

   task automatic test_backpressure();
      int lat;
      @(negedge clk);
      funct3 = 3'd5; rd1 = 100; rd2 = 7; forward_a_e = 0; forward_b_e = 0; rd_in = 5'd9; in_valid = 1; out_ready = 0;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 0;
      wait_valid(lat);
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_valid !== 1'b1 || result !== 32'd14 || rd_out !== 5'd9 || stall_e !== 1'b1)
            begin failures++; $display("FAIL hold_%0d valid=%b result=%0d rd=%0d stall=%b exp=1/14/9/1", i, out_valid, result, rd_out, stall_e); end
         @(posedge clk);
         @(negedge clk);
      end
      out_ready = 1;
      #1;
      checks++; if (stall_e !== 1'b0) begin failures++; $display("FAIL hold_release_stall got=%b exp=0", stall_e); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL hold_to_idle in_ready=%b valid=%b exp=1/0", in_ready, out_valid); end
   endtask

   task automatic test_rst_mid();
      @(negedge clk);
      funct3 = 3'd0; rd1 = 9; rd2 = 9; rd_in = 5'd20; in_valid = 1; out_ready = 1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      repeat (8) begin @(posedge clk); @(negedge clk); end
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0 || in_ready !== 1'b1 || stall_e !== 1'b0)
         begin failures++; $display("FAIL rst_mid valid=%b result=%h rd=%0d in_ready=%b stall=%b exp=0/0/0/1/0", out_valid, result, rd_out, in_ready, stall_e); end
      rst = 0;
   endtask

   task automatic test_bpc4();
      logic [31:0] a, b, e; logic [2:0] f; int lat, el;
      for (int i = 0; i < 8; i++) begin
         if (i == 0) begin f = 0; a = 7; b = 32'hFFFFFFFD; end
         else begin f = 3'($urandom_range(0, 7)); a = $urandom; b = (i == 1) ? 0 : $urandom; end
         e = model(f, a, b);
         el = special(f, a, b) ? 1 : 9;
         @(negedge clk);
         funct3 = f; rd1 = a; rd2 = b; forward_a_e = 0; forward_b_e = 0; iv4 = 1;
         @(posedge clk);
         lat = 1;
         @(negedge clk);
         iv4 = 0;
         while (!out_valid4 && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
         checks++; if (result4 !== e || lat != el)
            begin failures++; $display("FAIL bpc4_%0d f=%0d a=%h b=%h got=%h lat=%0d exp=%h lat=%0d", i, f, a, b, result4, lat, e, el); end
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_directed();
      test_random();
      test_forward();
      test_flush();
      test_backpressure();
      test_rst_mid();
      test_bpc4();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
